// File: rtl/input_conditioner.sv
// Pin front end: brings BTN/SW into the CLK1 domain, debounces buttons per bit and
// switches as a whole word, and emits clean levels plus one-cycle edge pulses.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK1,
    input  logic       RST_N,
    input  logic [1:0] BTN,
    input  logic [9:0] SW,
    output logic [1:0] BTN_LVL,
    output logic [1:0] BTN_PRESS,
    output logic [1:0] BTN_REL,
    output logic [9:0] SW_OUT,
    output logic       SW_CHG
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // Synchroniser stages; sw_s3_q exists only to detect a word still in motion.
    logic [1:0]            btn_s1_q;
    logic [1:0]            btn_s2_q;
    logic [9:0]            sw_s1_q;
    logic [9:0]            sw_s2_q;
    logic [9:0]            sw_s3_q;

    logic [1:0]            btn_lvl_q;
    logic [1:0]            btn_lvl_d;
    logic [1:0]            btn_press_q;
    logic [1:0]            btn_press_d;
    logic [1:0]            btn_rel_q;
    logic [1:0]            btn_rel_d;
    logic [1:0][CNT_W-1:0] btn_cnt_q;
    logic [1:0][CNT_W-1:0] btn_cnt_d;

    logic [9:0]            sw_out_q;
    logic [9:0]            sw_out_d;
    logic                  sw_chg_q;
    logic                  sw_chg_d;
    logic [CNT_W-1:0]      sw_cnt_q;
    logic [CNT_W-1:0]      sw_cnt_d;

    // Per-bit button debounce: accept a new level after DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        btn_lvl_d   = btn_lvl_q;
        btn_press_d = 2'b00;
        btn_rel_d   = 2'b00;
        btn_cnt_d   = btn_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (btn_s2_q[i] == btn_lvl_q[i]) begin
                btn_cnt_d[i] = CNT_ZERO;
            end else if (btn_cnt_q[i] == CNT_LAST) begin
                btn_lvl_d[i]   = btn_s2_q[i];
                btn_cnt_d[i]   = CNT_ZERO;
                btn_press_d[i] = ~btn_s2_q[i];
                btn_rel_d[i]   = btn_s2_q[i];
            end else begin
                btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Whole-word switch debounce: any bit still moving restarts the count.
    always_comb begin
        sw_out_d = sw_out_q;
        sw_chg_d = 1'b0;
        sw_cnt_d = sw_cnt_q;
        if ((sw_s2_q == sw_out_q) || (sw_s2_q != sw_s3_q)) begin
            sw_cnt_d = CNT_ZERO;
        end else if (sw_cnt_q == CNT_LAST) begin
            sw_out_d = sw_s2_q;
            sw_cnt_d = CNT_ZERO;
            sw_chg_d = 1'b1;
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    // State register; reset loads released buttons and an all-zero switch word.
    always_ff @(posedge CLK1) begin
        if (!RST_N) begin
            btn_s1_q    <= 2'b11;
            btn_s2_q    <= 2'b11;
            sw_s1_q     <= 10'd0;
            sw_s2_q     <= 10'd0;
            sw_s3_q     <= 10'd0;
            btn_lvl_q   <= 2'b11;
            btn_press_q <= 2'b00;
            btn_rel_q   <= 2'b00;
            btn_cnt_q   <= {2{CNT_ZERO}};
            sw_out_q    <= 10'd0;
            sw_chg_q    <= 1'b0;
            sw_cnt_q    <= CNT_ZERO;
        end else begin
            btn_s1_q    <= BTN;
            btn_s2_q    <= btn_s1_q;
            sw_s1_q     <= SW;
            sw_s2_q     <= sw_s1_q;
            sw_s3_q     <= sw_s2_q;
            btn_lvl_q   <= btn_lvl_d;
            btn_press_q <= btn_press_d;
            btn_rel_q   <= btn_rel_d;
            btn_cnt_q   <= btn_cnt_d;
            sw_out_q    <= sw_out_d;
            sw_chg_q    <= sw_chg_d;
            sw_cnt_q    <= sw_cnt_d;
        end
    end

    assign BTN_LVL   = btn_lvl_q;
    assign BTN_PRESS = btn_press_q;
    assign BTN_REL   = btn_rel_q;
    assign SW_OUT    = sw_out_q;
    assign SW_CHG    = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus
// random stimulus compared every cycle against a history-window reference model.
module tb_input_conditioner;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn;
    logic [9:0] sw;
    logic [1:0] btn_lvl, btn_press, btn_rel;
    logic [9:0] sw_out;
    logic       sw_chg;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: history of what the synchroniser delivers, one entry per edge.
    logic       model_valid = 1'b0;
    logic [1:0] exp_lvl   = 2'b11;
    logic [1:0] exp_press = 2'b00;
    logic [1:0] exp_rel   = 2'b00;
    logic [9:0] exp_sw    = 10'd0;
    logic       exp_chg   = 1'b0;
    logic [1:0] btn_h[$];
    logic [9:0] sw_h[$];

    input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK1      (clk),
        .RST_N     (rst_n),
        .BTN       (btn),
        .SW        (sw),
        .BTN_LVL   (btn_lvl),
        .BTN_PRESS (btn_press),
        .BTN_REL   (btn_rel),
        .SW_OUT    (sw_out),
        .SW_CHG    (sw_chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // A raw value sampled at edge k reaches s2 after edge k+1, so the value the
    // debouncer judges at edge k is the entry pushed two edges earlier. A reset
    // edge forces the synchroniser (and SW s3) back to reset values.
    task automatic model_step();
        int         n;
        logic       ok;
        logic [1:0] b;
        logic [9:0] w;
        exp_press = 2'b00;
        exp_rel   = 2'b00;
        exp_chg   = 1'b0;
        n = btn_h.size();
        if (!rst_n) begin
            btn_h[n-1] = 2'b11;
            btn_h[n-2] = 2'b11;
            sw_h[n-1]  = 10'd0;
            sw_h[n-2]  = 10'd0;
            btn_h.push_back(2'b11);
            sw_h.push_back(10'd0);
            exp_lvl     = 2'b11;
            exp_sw      = 10'd0;
            model_valid = 1'b1;
        end else begin
            btn_h.push_back(btn);
            sw_h.push_back(sw);
            n = btn_h.size();
            for (int i = 0; i < 2; i++) begin
                ok = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    b = btn_h[n-3-j];
                    if (b[i] == exp_lvl[i]) ok = 1'b0;
                end
                if (ok) begin
                    exp_lvl[i] = ~exp_lvl[i];
                    if (exp_lvl[i]) exp_rel[i] = 1'b1;
                    else            exp_press[i] = 1'b1;
                end
            end
            // The word must be identical over DC+1 consecutive samples (s2 and s3 agree).
            w  = sw_h[n-3];
            ok = (w != exp_sw);
            for (int j = 1; j <= DC; j++) begin
                if (sw_h[n-3-j] != w) ok = 1'b0;
            end
            if (ok) begin
                exp_sw  = w;
                exp_chg = 1'b1;
            end
        end
        while (btn_h.size() > 16) begin
            void'(btn_h.pop_front());
            void'(sw_h.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            btn_h.push_back(2'b11);
            sw_h.push_back(10'd0);
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                vectors++;
                if ({btn_lvl, btn_press, btn_rel, sw_out, sw_chg} !==
                    {exp_lvl, exp_press, exp_rel, exp_sw, exp_chg}) begin
                    miscompares++;
                    $display("FAIL model t=%0t: lvl %b/%b press %b/%b rel %b/%b sw %b/%b chg %b/%b (got/expected)",
                             $time, btn_lvl, exp_lvl, btn_press, exp_press, btn_rel, exp_rel,
                             sw_out, exp_sw, sw_chg, exp_chg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         first;
        int         cnt;
        int         cnt1;
        int         r;
        logic [9:0] steps [4];

        rst_n = 1'b0;
        btn   = 2'b11;
        sw    = 10'd0;
        repeat (3) tick();
        check("reset_state", {btn_lvl, btn_press, btn_rel, sw_out, sw_chg}, {2'b11, 2'b00, 2'b00, 10'd0, 1'b0});

        // 1: idle after reset release
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle", {btn_lvl, btn_press, btn_rel, sw_out, sw_chg}, {2'b11, 2'b00, 2'b00, 10'd0, 1'b0});
        end

        // 2: clean switch change, accepted on edge n+6
        sw = 10'b0010100101;
        first = -1; cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sw_chg) begin cnt++; if (first < 0) first = k; end
        end
        check("sw_latency", first, 6);
        check("sw_pulses", cnt, 1);
        check("sw_value", sw_out, 10'b0010100101);

        // 3: word stepping every cycle, only the final value is accepted
        steps[0] = 10'b0010100101;
        steps[1] = 10'b0110100101;
        steps[2] = 10'b1010100101;
        steps[3] = 10'b1110100101;
        cnt = 0; first = -1;
        for (int s = 0; s < 3; s++) begin
            sw = steps[s];
            tick();
            if (sw_chg) cnt++;
        end
        sw = steps[3];
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sw_chg) begin cnt++; if (first < 0) first = k; end
        end
        check("step_latency", first, 6);
        check("step_pulses", cnt, 1);
        check("step_value", sw_out, 10'b1110100101);

        // 4: bouncing BTN[0] press
        cnt = 0; cnt1 = 0; first = -1;
        btn = 2'b10; tick(); if (btn_press[0]) cnt++;
        btn = 2'b10; tick(); if (btn_press[0]) cnt++;
        btn = 2'b11; tick(); if (btn_press[0]) cnt++;
        btn = 2'b10;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_press[0]) begin cnt++; if (first < 0) first = k; end
            if (btn_press[1] || btn_rel[1]) cnt1++;
        end
        check("btn0_latency", first, 5);
        check("btn0_presses", cnt, 1);
        check("btn0_level", btn_lvl, 2'b10);
        check("btn1_quiet", cnt1, 0);
        btn = 2'b11;
        repeat (12) tick();
        check("btn0_released", btn_lvl, 2'b11);

        // 5: both buttons together
        btn = 2'b00; cnt = 0; first = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_press == 2'b11) begin cnt++; if (first < 0) first = k; end
        end
        check("both_press_at", first, 5);
        check("both_press_cnt", cnt, 1);
        btn = 2'b11; cnt = 0; first = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (btn_rel == 2'b11) begin cnt++; if (first < 0) first = k; end
        end
        check("both_rel_at", first, 5);
        check("both_rel_cnt", cnt, 1);
        check("both_level", btn_lvl, 2'b11);

        // 6: reset in the middle of a switch debounce
        sw = 10'h155;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("mid_reset_sw", {sw_out, sw_chg}, {10'd0, 1'b0});
        rst_n = 1'b1; cnt = 0; first = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (sw_chg) begin cnt++; if (first < 0) first = k; end
        end
        check("post_reset_latency", first, 6);
        check("post_reset_pulses", cnt, 1);
        check("post_reset_value", sw_out, 10'h155);

        // Random phase: sparse flips and bursts so both bounces and acceptances occur.
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 999));
            rst_n = (r == 999) ? 1'b0 : 1'b1;
            if (r < 40)       btn[$urandom_range(0, 1)] ^= 1'b1;
            else if (r < 55)  btn = 2'($urandom_range(0, 3));
            else if (r < 90)  sw[$urandom_range(0, 9)] ^= 1'b1;
            else if (r < 100) sw = 10'($urandom_range(0, 1023));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
